// File: rtl/apb_req_master.sv
// apb_req_master: single-outstanding APB master.
// Converts a valid/ready request stream into APB SETUP/ACCESS transfers and
// returns read data plus error status on a valid/ready response stream.
// A programmable access timeout guarantees forward progress.
//
// Ports:
//   pclk, preset                 clock, synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_write/addr/wdata/sel     request payload (sel is a slave index)
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata/err/timeout        response payload
//   paddr/pwrite/pwdata/psel/penable   APB master outputs
//   prdata/pready/pslverr              APB slave returns
module apb_req_master #(
  parameter int unsigned NUM_SLAVES = 16,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [31:0]           paddr,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  // A disabled timeout still keeps a 1-bit counter so no zero-width vector exists.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  req_ready_d;
  logic                  rsp_valid_d;
  logic [NUM_SLAVES-1:0] psel_d;
  logic                  penable_d;
  logic [31:0]           paddr_d;
  logic                  pwrite_d;
  logic [31:0]           pwdata_d;
  logic [31:0]           rsp_rdata_d;
  logic                  rsp_err_d;
  logic                  rsp_timeout_d;
  logic                  sel_ok;
  logic [NUM_SLAVES-1:0] sel_onehot;

  // Slave index decode; out-of-range indices produce a decode error.
  always_comb begin
    sel_ok = (32'(req_sel) < NUM_SLAVES);
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      sel_onehot[i] = (32'(req_sel) == i);
    end
  end

  // State and registered outputs.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      psel        <= '0;
      penable     <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      psel        <= psel_d;
      penable     <= penable_d;
      paddr       <= paddr_d;
      pwrite      <= pwrite_d;
      pwdata      <= pwdata_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = '0;
    paddr_d       = paddr;
    pwrite_d      = pwrite;
    pwdata_d      = pwdata;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;

    case (state_q)
      IDLE: begin
        // req_ready is registered; it is also 0 in the first cycle after reset.
        if (req_valid && req_ready) begin
          if (sel_ok) begin
            state_d  = SETUP;
            psel_d   = sel_onehot;
            paddr_d  = req_addr;
            pwrite_d = req_write;
            pwdata_d = req_wdata;
            cnt_d    = '0;
          end else begin
            state_d       = RESP;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        psel_d  = psel;
      end
      ACCESS: begin
        if (pready) begin
          state_d       = RESP;
          rsp_rdata_d   = pwrite ? 32'd0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else if ((TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          // This is the TIMEOUT-th access cycle without pready.
          state_d       = RESP;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          psel_d = psel;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    penable_d   = (state_d == ACCESS);
  end

endmodule

// File: tb/tb_apb_req_master.sv
// Testbench for apb_req_master (NUM_SLAVES=4, TIMEOUT=4): table-driven
// directed vectors, randomized transactions against a transaction-level
// model, plus hand-written reset sequences.
module tb_apb_req_master;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          preset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_sel;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [31:0]   paddr;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic [NS-1:0] psel;
  logic          penable;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  apb_req_master #(.NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
    .pclk(clk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel),
    .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          waits;     // pready-low ACCESS cycles before pready
    int          hold;      // cycles rsp_ready is held low
    int          exp_lat;   // cycles from acceptance edge to first rsp_valid
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_rdata;
    int          exp_pen;   // number of penable cycles
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_addr = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: outcome follows from slave index, wait count and timeout.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (int'(v.sel) >= int'(NS)) begin
      r.exp_lat = 1; r.exp_err = 1'b1; r.exp_to = 1'b0; r.exp_rdata = 32'd0; r.exp_pen = 0;
    end else if (v.waits >= int'(TO)) begin
      r.exp_lat = 2 + int'(TO); r.exp_err = 1'b1; r.exp_to = 1'b1;
      r.exp_rdata = 32'd0; r.exp_pen = int'(TO);
    end else begin
      r.exp_lat = 3 + v.waits; r.exp_err = v.slverr; r.exp_to = 1'b0;
      r.exp_rdata = v.write ? 32'd0 : v.prdata; r.exp_pen = v.waits + 1;
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v);
    logic [NS-1:0] oh;
    logic          decode_err;
    int            pen = 0;
    int            selc = 0;
    int            held = 0;
    bit            seen = 0;
    bit            done = 0;
    decode_err = (int'(v.sel) >= int'(NS));
    oh = decode_err ? '0 : (NS'(1) << v.sel);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
    req_wdata = v.wdata; req_sel = v.sel;
    prdata = v.prdata; pslverr = v.slverr; pready = 1'b0;
    rsp_ready = (v.hold == 0);
    @(posedge clk);
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (penable && psel == '0) chk("penable_without_psel", 32'(psel), 32'(oh));
      if (psel != '0) begin
        selc++;
        chk("psel_onehot", 32'(psel), 32'(oh));
        chk("paddr_stable", paddr, v.addr);
        chk("pwrite", 32'(pwrite), 32'(v.write));
        chk("pwdata", pwdata, v.wdata);
      end
      if (decode_err) chk("paddr_held", paddr, last_addr);
      if (penable) pen++;
      pready = penable && (pen == v.waits + 1);
      if (rsp_valid) begin
        if (!seen) chk("rsp_latency", 32'(c), 32'(v.exp_lat));
        else       chk("bp_req_ready", 32'(req_ready), 32'd0);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_to));
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        seen = 1;
        if (held >= v.hold) begin
          rsp_ready = 1'b1;
          done = 1;
        end else begin
          held++;
        end
      end
    end
    if (!done) chk("rsp_budget_expired", 32'(seen), 32'd2);
    chk("penable_cycles", 32'(pen), 32'(v.exp_pen));
    chk("psel_cycles", 32'(selc), decode_err ? 32'd0 : 32'(v.exp_pen + 1));
    @(negedge clk);
    pready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    if (!decode_err) last_addr = v.addr;
  endtask

  vec_t vt[8];
  vec_t rv;

  initial begin
    preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_sel = '0; rsp_ready = 1'b1;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;

    //       wr    sel   addr          wdata         prdata        err   w   h   lat eerr eto  erdata        pen
    vt[0] = '{1'b1, 4'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1'b0, 0,  0, 3, 1'b0, 1'b0, 32'h0,        1};
    vt[1] = '{1'b0, 4'd1, 32'h0000_0200, 32'h0,        32'h1234_5678, 1'b0, 3,  0, 6, 1'b0, 1'b0, 32'h1234_5678, 4};
    vt[2] = '{1'b1, 4'd0, 32'h0000_0300, 32'h5555,     32'h0,        1'b1, 0,  0, 3, 1'b1, 1'b0, 32'h0,        1};
    vt[3] = '{1'b0, 4'd3, 32'h0000_0400, 32'h0,        32'h77,       1'b0, 99, 0, 6, 1'b1, 1'b1, 32'h0,        4};
    vt[4] = '{1'b0, 4'd3, 32'h0000_0404, 32'h0,        32'h88,       1'b0, 3,  0, 6, 1'b0, 1'b0, 32'h88,       4};
    vt[5] = '{1'b0, 4'd7, 32'h0000_0500, 32'h0,        32'h99,       1'b0, 0,  0, 1, 1'b1, 1'b0, 32'h0,        0};
    vt[6] = '{1'b0, 4'd1, 32'h0000_0600, 32'h0,        32'hCAFE_F00D, 1'b0, 1,  5, 4, 1'b0, 1'b0, 32'hCAFE_F00D, 2};
    vt[7] = '{1'b1, 4'd3, 32'h0000_0700, 32'h1234,     32'h0,        1'b0, 2,  0, 5, 1'b0, 1'b0, 32'h0,        3};

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {30'd0, rsp_err, rsp_timeout}, 32'd0);
    preset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_txn(vt[i]);

    // Reset during ACCESS discards the transfer.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0800; req_sel = 4'd1;
    pready = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_penable", 32'(penable), 32'd1);
    preset = 1'b1;
    @(negedge clk);
    chk("mid_rst_psel", 32'(psel), 32'd0);
    chk("mid_rst_penable", 32'(penable), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    preset = 1'b0;
    last_addr = 32'd0;
    @(negedge clk);
    chk("mid_rst_recover", 32'(req_ready), 32'd1);
    chk("mid_rst_quiet", 32'(rsp_valid), 32'd0);

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      rv.write  = 1'($urandom_range(0, 1));
      rv.sel    = 4'($urandom_range(0, 5));
      rv.addr   = $urandom;
      rv.wdata  = $urandom;
      rv.prdata = $urandom;
      rv.slverr = ($urandom_range(0, 3) == 0);
      if (rv.slverr && !rv.write) rv.prdata = 32'd0;
      rv.waits  = int'($urandom_range(0, 6));
      rv.hold   = int'($urandom_range(0, 2));
      rv = model(rv);
      run_txn(rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
